// File: rtl/wb8_pkg.sv
// Shared types and constants for the 8-bit Wishbone address decoder.
// Holds the FSM state encoding, the error read-data value and the select-index width helper.
package wb8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } wb8_state_t;

  localparam logic [7:0] WB8_ERR_DATA = 8'hFF;

  // One extra code point so that NUM_SLAVES itself can mean "no slave".
  function automatic int wb8_idx_w(input int num_slaves);
    return $clog2(num_slaves + 1);
  endfunction

endpackage

// File: rtl/wb8_addr_match.sv
// Combinational base/mask priority matcher; the lowest matching slave index wins.
module wb8_addr_match #(
  parameter int                       NUM_SLAVES = 4,
  parameter int                       IDX_W      = 3,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = '0
) (
  input  logic [31:0]      i_adr,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top down so the last (lowest-index) hit overrides.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((i_adr & SLAVE_MASK[32*i +: 32]) ==
          (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32])) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb8_bus_decoder.sv
// Wishbone 8-bit address decoder / response mux with latched selection and bus watchdog.
// Optional fault capture registers are built when WB8_DEC_FAULT_CAPTURE_EN is defined.
module wb8_bus_decoder
  import wb8_pkg::*;
#(
  parameter int                       NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {32'hFFFFFD00, 32'hFFFFF900, 32'hFFFFF800, 32'hFFFFF000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFF800},
  parameter int                       DEFAULT_SLAVE  = NUM_SLAVES,
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter int                       TIMEOUT_W      = 8
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic [31:0]             ADR_I,
  input  logic                    CYC_I,
  input  logic                    STB_I,
  output logic [7:0]              DAT_O,
  output logic                    ACK_O,
  output logic                    ERR_O,
  output logic [NUM_SLAVES-1:0]   S_STB_O,
  input  logic [NUM_SLAVES*8-1:0] S_DAT_I,
`ifdef WB8_DEC_FAULT_CAPTURE_EN
  output logic                    O_fault_valid,
  output logic [31:0]             O_fault_adr,
  output logic                    O_fault_timeout,
  input  logic                    I_fault_clear,
`endif
  input  logic [NUM_SLAVES-1:0]   S_ACK_I
);

  localparam int IDX_W = wb8_idx_w(NUM_SLAVES);
  // The counter reaches TIMEOUT_CYCLES on the edge that leaves ACTIVE, so compare one short.
  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  wb8_state_t           r_state;
  wb8_state_t           w_nxt;
  logic [IDX_W-1:0]     r_sel;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 w_hit;
  logic [IDX_W-1:0]     w_match_idx;
  logic [IDX_W-1:0]     w_dec_sel;
  logic                 w_dec_valid;
  logic                 w_sel_ack;
  logic [7:0]           w_sel_dat;
  logic                 w_timeout;

  wb8_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_match (
    .i_adr (ADR_I),
    .o_hit (w_hit),
    .o_idx (w_match_idx)
  );

  assign w_dec_sel   = w_hit ? w_match_idx : IDX_W'(DEFAULT_SLAVE);
  assign w_dec_valid = (w_dec_sel < IDX_W'(NUM_SLAVES));
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

  always_comb begin
    w_sel_ack = 1'b0;
    w_sel_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel == IDX_W'(i)) begin
        w_sel_ack = S_ACK_I[i];
        w_sel_dat = S_DAT_I[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == ST_IDLE && w_nxt == ST_ACTIVE) begin
        r_sel <= w_dec_sel;
        r_cnt <= '0;
      end else if (r_state == ST_ACTIVE && !w_sel_ack) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (CYC_I && STB_I) w_nxt = w_dec_valid ? ST_ACTIVE : ST_ERROR;
      end
      ST_ACTIVE: begin
        if (!CYC_I)         w_nxt = ST_IDLE;
        else if (w_sel_ack) w_nxt = ST_IDLE;
        else if (w_timeout) w_nxt = ST_ERROR;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    S_STB_O = '0;
    DAT_O   = '0;
    ACK_O   = 1'b0;
    ERR_O   = 1'b0;
    case (r_state)
      ST_ACTIVE: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (r_sel == IDX_W'(i)) S_STB_O[i] = STB_I;
        end
        DAT_O = w_sel_dat;
        // An aborted cycle must never see a termination.
        ACK_O = w_sel_ack && CYC_I;
      end
      ST_ERROR: begin
        DAT_O = WB8_ERR_DATA;
        ACK_O = 1'b1;
        ERR_O = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef WB8_DEC_FAULT_CAPTURE_EN
  logic        r_fault_valid;
  logic [31:0] r_fault_adr;
  logic        r_fault_timeout;
  logic        w_fault_entry;

  assign w_fault_entry = (w_nxt == ST_ERROR) && (r_state != ST_ERROR);

  // Clear first so a fault in the same cycle still lands.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_fault_valid   <= 1'b0;
      r_fault_adr     <= '0;
      r_fault_timeout <= 1'b0;
    end else begin
      if (I_fault_clear) r_fault_valid <= 1'b0;
      if (w_fault_entry && (!r_fault_valid || I_fault_clear)) begin
        r_fault_valid   <= 1'b1;
        r_fault_adr     <= ADR_I;
        r_fault_timeout <= (r_state == ST_ACTIVE);
      end
    end
  end

  assign O_fault_valid   = r_fault_valid;
  assign O_fault_adr     = r_fault_adr;
  assign O_fault_timeout = r_fault_timeout;
`endif

endmodule

// File: tb/tb_wb8_bus_decoder.sv
// Self-checking bench for wb8_bus_decoder with behavioural slaves and an expected-response queue.
// Fault capture checks are compiled in when WB8_DEC_FAULT_CAPTURE_EN is defined.
module tb_wb8_bus_decoder;

  typedef struct {
    logic       err;
    logic [7:0] dat;
    int         cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic        cyc;
  logic        stb;
  logic [7:0]  dat_o;
  logic        ack_o;
  logic        err_o;
  logic [3:0]  s_stb;
  logic [31:0] s_dat;
  logic [3:0]  s_ack;
`ifdef WB8_DEC_FAULT_CAPTURE_EN
  logic        f_valid;
  logic [31:0] f_adr;
  logic        f_timeout;
  logic        f_clear;
`endif

  int   lat [4];
  int   stb_cnt [4];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // Slave 2 overlaps slave 0's region so index priority can be exercised.
  wb8_bus_decoder #(
    .NUM_SLAVES     (4),
    .SLAVE_BASE     ({32'hFFFFFD00, 32'hFFFFF100, 32'hFFFFF800, 32'hFFFFF000}),
    .SLAVE_MASK     ({32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFF800}),
    .DEFAULT_SLAVE  (4),
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_W      (8)
  ) dut (
    .CLK_I   (clk),
    .RST_I   (rst),
    .ADR_I   (adr),
    .CYC_I   (cyc),
    .STB_I   (stb),
    .DAT_O   (dat_o),
    .ACK_O   (ack_o),
    .ERR_O   (err_o),
    .S_STB_O (s_stb),
    .S_DAT_I (s_dat),
`ifdef WB8_DEC_FAULT_CAPTURE_EN
    .O_fault_valid   (f_valid),
    .O_fault_adr     (f_adr),
    .O_fault_timeout (f_timeout),
    .I_fault_clear   (f_clear),
`endif
    .S_ACK_I (s_ack)
  );

  // ROM, UART, overlap slave, timer read bytes.
  assign s_dat = {8'h71, 8'hC3, 8'h5A, 8'h93};

  // A slave acks once its strobe has been high for lat[i] earlier cycles; lat 0 never acks.
  always_comb begin
    s_ack = '0;
    for (int i = 0; i < 4; i++)
      s_ack[i] = s_stb[i] && (lat[i] != 0) && (stb_cnt[i] == lat[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst || !s_stb[i] || s_ack[i]) stb_cnt[i] <= 0;
      else                              stb_cnt[i] <= stb_cnt[i] + 1;
    end
  end

  task automatic run_access(input logic [31:0] a, input int max_cyc, output int cycles,
                            output logic got_ack, output logic got_err, output logic [7:0] got_dat,
                            output logic [3:0] stb_or, output int stb_hi);
    adr = a; cyc = 1'b1; stb = 1'b1;
    cycles = 0; got_ack = 1'b0; got_err = 1'b0; got_dat = '0; stb_or = '0; stb_hi = 0;
    while (!got_ack && cycles < max_cyc) begin
      @(negedge clk);
      cycles++;
      stb_or |= s_stb;
      if (|s_stb) stb_hi++;
      if (ack_o === 1'b1) begin
        got_ack = 1'b1; got_err = err_o; got_dat = dat_o;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

`ifdef WB8_DEC_FAULT_CAPTURE_EN
  task automatic pulse_clear();
    f_clear = 1'b1;
    @(posedge clk); #1;
    f_clear = 1'b0;
  endtask
`endif

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", ack_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    n_cmp++; if (dat_o !== 8'h00) begin n_bad++; $display("FAIL reset_dat: got %h want 00", dat_o); end
    n_cmp++; if (s_stb !== 4'b0) begin n_bad++; $display("FAIL reset_stb: got %b want 0000", s_stb); end
`ifdef WB8_DEC_FAULT_CAPTURE_EN
    n_cmp++; if (f_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fault_valid: got %b want 0", f_valid); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_rom_read();
    int c, hi; logic a, e; logic [7:0] d; logic [3:0] so; exp_t x;
    sb.push_back('{1'b0, 8'h93, 3});
    run_access(32'hFFFFF004, 20, c, a, e, d, so, hi);
    x = sb.pop_front();
    n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL rom_ack: got %b want 1", a); end
    n_cmp++; if (e !== x.err) begin n_bad++; $display("FAIL rom_err: got %b want %b", e, x.err); end
    n_cmp++; if (d !== x.dat) begin n_bad++; $display("FAIL rom_dat: got %h want %h", d, x.dat); end
    n_cmp++; if (c != x.cycles) begin n_bad++; $display("FAIL rom_cycles: got %0d want %0d", c, x.cycles); end
    n_cmp++; if (so !== 4'b0001) begin n_bad++; $display("FAIL rom_stb: got %b want 0001", so); end
    n_cmp++; if (hi != 2) begin n_bad++; $display("FAIL rom_stb_cycles: got %0d want 2", hi); end
  endtask

  task automatic test_unmapped();
    int c, hi; logic a, e; logic [7:0] d; logic [3:0] so; exp_t x;
    sb.push_back('{1'b1, 8'hFF, 2});
    run_access(32'h00001000, 20, c, a, e, d, so, hi);
    x = sb.pop_front();
    n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL unmapped_ack: got %b want 1", a); end
    n_cmp++; if (e !== x.err) begin n_bad++; $display("FAIL unmapped_err: got %b want %b", e, x.err); end
    n_cmp++; if (d !== x.dat) begin n_bad++; $display("FAIL unmapped_dat: got %h want %h", d, x.dat); end
    n_cmp++; if (c != x.cycles) begin n_bad++; $display("FAIL unmapped_cycles: got %0d want %0d", c, x.cycles); end
    n_cmp++; if (so !== 4'b0000) begin n_bad++; $display("FAIL unmapped_stb: got %b want 0000", so); end
    @(negedge clk);
    n_cmp++; if (ack_o !== 1'b0) begin n_bad++; $display("FAIL unmapped_single_ack: got %b want 0", ack_o); end
`ifdef WB8_DEC_FAULT_CAPTURE_EN
    n_cmp++; if (f_valid !== 1'b1) begin n_bad++; $display("FAIL unmapped_fvalid: got %b want 1", f_valid); end
    n_cmp++; if (f_adr !== 32'h00001000) begin n_bad++; $display("FAIL unmapped_fadr: got %h want 00001000", f_adr); end
    n_cmp++; if (f_timeout !== 1'b0) begin n_bad++; $display("FAIL unmapped_fto: got %b want 0", f_timeout); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int c, hi; logic a, e; logic [7:0] d; logic [3:0] so; exp_t x;
`ifdef WB8_DEC_FAULT_CAPTURE_EN
    pulse_clear();
`endif
    lat[3] = 0;
    sb.push_back('{1'b1, 8'hFF, 6});
    run_access(32'hFFFFFD10, 20, c, a, e, d, so, hi);
    x = sb.pop_front();
    n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL timeout_ack: got %b want 1", a); end
    n_cmp++; if (e !== x.err) begin n_bad++; $display("FAIL timeout_err: got %b want %b", e, x.err); end
    n_cmp++; if (d !== x.dat) begin n_bad++; $display("FAIL timeout_dat: got %h want %h", d, x.dat); end
    n_cmp++; if (c != x.cycles) begin n_bad++; $display("FAIL timeout_cycles: got %0d want %0d", c, x.cycles); end
    n_cmp++; if (so !== 4'b1000) begin n_bad++; $display("FAIL timeout_stb: got %b want 1000", so); end
    n_cmp++; if (hi != 4) begin n_bad++; $display("FAIL timeout_stb_cycles: got %0d want 4", hi); end
`ifdef WB8_DEC_FAULT_CAPTURE_EN
    n_cmp++; if (f_valid !== 1'b1) begin n_bad++; $display("FAIL timeout_fvalid: got %b want 1", f_valid); end
    n_cmp++; if (f_adr !== 32'hFFFFFD10) begin n_bad++; $display("FAIL timeout_fadr: got %h want FFFFFD10", f_adr); end
    n_cmp++; if (f_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_fto: got %b want 1", f_timeout); end
`endif
  endtask

  task automatic test_ack_at_limit();
    int c, hi; logic a, e; logic [7:0] d; logic [3:0] so; exp_t x;
`ifdef WB8_DEC_FAULT_CAPTURE_EN
    pulse_clear();
`endif
    lat[3] = 3;
    sb.push_back('{1'b0, 8'h71, 5});
    run_access(32'hFFFFFD00, 20, c, a, e, d, so, hi);
    x = sb.pop_front();
    n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL limit_ack: got %b want 1", a); end
    n_cmp++; if (e !== x.err) begin n_bad++; $display("FAIL limit_err: got %b want %b", e, x.err); end
    n_cmp++; if (d !== x.dat) begin n_bad++; $display("FAIL limit_dat: got %h want %h", d, x.dat); end
    n_cmp++; if (c != x.cycles) begin n_bad++; $display("FAIL limit_cycles: got %0d want %0d", c, x.cycles); end
    n_cmp++; if (hi != 4) begin n_bad++; $display("FAIL limit_stb_cycles: got %0d want 4", hi); end
    @(negedge clk);
    n_cmp++; if (ack_o !== 1'b0) begin n_bad++; $display("FAIL limit_no_err_cycle: got ack %b want 0", ack_o); end
`ifdef WB8_DEC_FAULT_CAPTURE_EN
    n_cmp++; if (f_valid !== 1'b0) begin n_bad++; $display("FAIL limit_fvalid: got %b want 0", f_valid); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_abort_then_uart();
    int c, hi, acks; logic a, e; logic [7:0] d; logic [3:0] so; exp_t x;
    lat[3] = 0;
    acks = 0;
    adr = 32'hFFFFFD00; cyc = 1'b1; stb = 1'b1;
    repeat (3) begin @(negedge clk); if (ack_o === 1'b1) acks++; end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    if (ack_o === 1'b1) acks++;
    n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL abort_ack: got %0d acks want 0", acks); end
    n_cmp++; if (s_stb !== 4'b0) begin n_bad++; $display("FAIL abort_stb: got %b want 0000", s_stb); end
    @(posedge clk); #1;
    sb.push_back('{1'b0, 8'h5A, 3});
    run_access(32'hFFFFF800, 20, c, a, e, d, so, hi);
    x = sb.pop_front();
    n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL uart_ack: got %b want 1", a); end
    n_cmp++; if (e !== x.err) begin n_bad++; $display("FAIL uart_err: got %b want %b", e, x.err); end
    n_cmp++; if (d !== x.dat) begin n_bad++; $display("FAIL uart_dat: got %h want %h", d, x.dat); end
    n_cmp++; if (c != x.cycles) begin n_bad++; $display("FAIL uart_cycles: got %0d want %0d", c, x.cycles); end
    n_cmp++; if (so !== 4'b0010) begin n_bad++; $display("FAIL uart_stb: got %b want 0010", so); end
  endtask

  task automatic test_overlap_reset();
    int acks;
    lat[0] = 0;
    acks = 0;
    adr = 32'hFFFFF104; cyc = 1'b1; stb = 1'b1;
    repeat (2) begin @(negedge clk); if (ack_o === 1'b1) acks++; end
    n_cmp++; if (s_stb !== 4'b0001) begin n_bad++; $display("FAIL overlap_sel: got %b want 0001", s_stb); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    if (ack_o === 1'b1) acks++;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL rst_abort_ack: got %0d acks want 0", acks); end
    n_cmp++; if (s_stb !== 4'b0) begin n_bad++; $display("FAIL rst_stb: got %b want 0000", s_stb); end
    n_cmp++; if (ack_o !== 1'b0 || err_o !== 1'b0) begin n_bad++; $display("FAIL rst_ack_err: got %b%b want 00", ack_o, err_o); end
    n_cmp++; if (dat_o !== 8'h00) begin n_bad++; $display("FAIL rst_dat: got %h want 00", dat_o); end
    // An idle-looking state must not start an access with CYC low.
    @(negedge clk);
    n_cmp++; if (s_stb !== 4'b0) begin n_bad++; $display("FAIL rst_idle_stb: got %b want 0000", s_stb); end
    lat[0] = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; adr = '0; cyc = 1'b0; stb = 1'b0;
`ifdef WB8_DEC_FAULT_CAPTURE_EN
    f_clear = 1'b0;
`endif
    lat = '{1, 1, 1, 1};
    test_reset();
    test_rom_read();
    test_unmapped();
    test_timeout();
    test_ack_at_limit();
    test_abort_then_uart();
    test_overlap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang want completion");
    $fatal(1, "bench time limit");
  end

endmodule
